// File: rtl/alu_pkg.sv
// Shared definitions for the sequential 32-bit adder: data widths, the
// controller state encoding and the signed-overflow helper.
package alu_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign but the result does not.
    function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/FullAdder16.sv
// 16-bit ripple adder slice, time-shared by seq_adder32 across both halves.
module FullAdder16
    import alu_pkg::*;
(
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    input  logic              cin,
    output logic [HALF_W-1:0] s,
    output logic              cout
);

    logic [HALF_W:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, cin};
    assign s       = total_s[HALF_W-1:0];
    assign cout    = total_s[HALF_W];

endmodule

// File: rtl/seq_adder32.sv
// Sequential 32-bit add/subtract: one 16-bit adder reused for the low half
// and then the high half, result and done pulse registered.
// Optional feature: define SEQ_ADDER32_OVERFLOW_EN to add the registered
// signed-overflow output.
module seq_adder32
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sub,
    input  logic              cIn,
    input  logic [WORD_W-1:0] in1,
    input  logic [WORD_W-1:0] in2,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] sum,
    output logic              cOut
`ifdef SEQ_ADDER32_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);

    state_t            state_r;
    logic [WORD_W-1:0] a_r;
    logic [WORD_W-1:0] b_r;          // already inverted for subtract
    logic [WORD_W-1:0] sum_r;
    logic              carry_in_r;   // carry into bit 0 (1 for subtract)
    logic              carry_int_r;  // carry from bit 15 into bit 16
    logic              cout_r;
    logic              done_r;
`ifdef SEQ_ADDER32_OVERFLOW_EN
    logic              ovf_r;
`endif

    logic [HALF_W-1:0] fa_a_s;
    logic [HALF_W-1:0] fa_b_s;
    logic [HALF_W-1:0] fa_s_s;
    logic              fa_ci_s;
    logic              fa_co_s;

    // Route the operand half and carry-in matching the current phase into the shared adder.
    always_comb begin
        fa_a_s  = a_r[HALF_W-1:0];
        fa_b_s  = b_r[HALF_W-1:0];
        fa_ci_s = carry_in_r;
        case (state_r)
            ST_HIGH: begin
                fa_a_s  = a_r[WORD_W-1:HALF_W];
                fa_b_s  = b_r[WORD_W-1:HALF_W];
                fa_ci_s = carry_int_r;
            end
            default: begin
                fa_a_s  = a_r[HALF_W-1:0];
                fa_b_s  = b_r[HALF_W-1:0];
                fa_ci_s = carry_in_r;
            end
        endcase
    end

    FullAdder16 u_fa (
        .a    (fa_a_s),
        .b    (fa_b_s),
        .cin  (fa_ci_s),
        .s    (fa_s_s),
        .cout (fa_co_s)
    );

    // Controller: capture operands, low half, high half, then a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= {WORD_W{1'b0}};
            b_r         <= {WORD_W{1'b0}};
            sum_r       <= {WORD_W{1'b0}};
            carry_in_r  <= 1'b0;
            carry_int_r <= 1'b0;
            cout_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef SEQ_ADDER32_OVERFLOW_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r        <= in1;
                        b_r        <= sub ? ~in2 : in2;
                        carry_in_r <= sub ? 1'b1 : cIn;
                        state_r    <= ST_LOW;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    sum_r[HALF_W-1:0] <= fa_s_s;
                    carry_int_r       <= fa_co_s;
                    state_r           <= ST_HIGH;
                end
                ST_HIGH: begin
                    sum_r[WORD_W-1:HALF_W] <= fa_s_s;
                    cout_r                 <= fa_co_s;
                    done_r                 <= 1'b1;
`ifdef SEQ_ADDER32_OVERFLOW_EN
                    ovf_r <= ovf_detect(a_r[WORD_W-1], b_r[WORD_W-1], fa_s_s[HALF_W-1]);
`endif
                    state_r                <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);
    assign done = done_r;
    assign sum  = sum_r;
    assign cOut = cout_r;
`ifdef SEQ_ADDER32_OVERFLOW_EN
    assign overflow = ovf_r;
`endif

endmodule
